ft232h_rx: RTL and testbench

//  Receive path (USB host -> FPGA) of the FT232H synchronous 245 FIFO interface.

---
 rtl/ftdi_pkg.sv | 14 +
 rtl/ft232h_rx_fifo.sv | 73 +++++++
 rtl/ft232h_rx.sv | 167 ++++++++++++++++
 tb/tb_ft232h_rx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ftdi_pkg.sv
// Shared types and constants for the FT232H synchronous 245 FIFO receive path.
package ftdi_pkg;

   localparam int FTDI_DATA_WIDTH = 8;

   // Receive sequencer states: bus idle, OE# turnaround, RD# strobing, bus held waiting for room
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TURN  = 2'd1,
      READ  = 2'd2,
      PAUSE = 2'd3
   } ftdi_rx_state_t;

endpackage

// File: rtl/ft232h_rx_fifo.sv
// Single-clock capture buffer with first-word-fall-through head and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module ft232h_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [AW:0]      count
);

   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok_s;
   logic             pop_ok_s;

   // Next-state pointers and occupancy; a push into a full buffer or a pop from an empty one is ignored
   always_comb begin
      push_ok_s = push && (count_q != CW'(DEPTH));
      pop_ok_s  = pop && (count_q != {CW{1'b0}});
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers; reset empties the buffer
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset because count gates visibility
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/ft232h_rx.sv
// FT232H synchronous 245 FIFO receive path: sequences OE# then RD# while RXF# is low,
// captures ADBUS into a small buffer and drains it onto an AXI-Stream master.
// Optional feature macro: FT232H_RX_BYTE_COUNT_EN adds a 32-bit wrapping capture counter.
module ft232h_rx
   import ftdi_pkg::*;
#(
   parameter int BUF_DEPTH = 4
) (
   input  logic                       ftdi_clk,
   input  logic                       ftdi_reset,
   input  logic                       ftdi_rxf_n,
   output logic                       ftdi_oe_n,
   output logic                       ftdi_rd_n,
   input  logic [FTDI_DATA_WIDTH-1:0] ftdi_adbus,
   output logic [FTDI_DATA_WIDTH-1:0] host_axis_tdata,
   output logic                       host_axis_tvalid,
   input  logic                       host_axis_tready
`ifdef FT232H_RX_BYTE_COUNT_EN
   ,
   output logic [31:0]                rx_byte_count
`endif
);

   localparam int AW = $clog2(BUF_DEPTH);
   localparam int CW = AW + 1;

   ftdi_rx_state_t state_q, state_d;
   logic           oe_n_q, oe_n_d;
   logic           rd_n_q, rd_n_d;
   logic [CW-1:0]  fifo_count_s;
   logic [CW-1:0]  count_next_s;
   logic           capture_s;
   logic           pop_s;
   logic           tvalid_s;
   logic           space_s;

   assign capture_s    = !rd_n_q && !ftdi_rxf_n;
   assign tvalid_s     = (fifo_count_s != {CW{1'b0}});
   assign pop_s        = tvalid_s && host_axis_tready;
   // Room is judged on the occupancy after this edge, so a strobe never lands in a full buffer
   assign count_next_s = fifo_count_s + CW'(capture_s) - CW'(pop_s);
   assign space_s      = (count_next_s < CW'(BUF_DEPTH));

   ft232h_rx_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (FTDI_DATA_WIDTH)
   ) u_fifo (
      .clk       (ftdi_clk),
      .rst       (ftdi_reset),
      .push      (capture_s),
      .push_data (ftdi_adbus),
      .pop       (pop_s),
      .head_data (host_axis_tdata),
      .count     (fifo_count_s)
   );

   // Sequencer next state; OE# always leads RD# by at least one edge and RD# never lows with OE# high
   always_comb begin
      state_d = state_q;
      oe_n_d  = oe_n_q;
      rd_n_d  = rd_n_q;
      case (state_q)
         IDLE: begin
            rd_n_d = 1'b1;
            if (!ftdi_rxf_n && space_s) begin
               oe_n_d  = 1'b0;
               state_d = TURN;
            end else begin
               oe_n_d  = 1'b1;
               state_d = IDLE;
            end
         end
         TURN: begin
            if (ftdi_rxf_n) begin
               oe_n_d  = 1'b1;
               rd_n_d  = 1'b1;
               state_d = IDLE;
            end else if (space_s) begin
               oe_n_d  = 1'b0;
               rd_n_d  = 1'b0;
               state_d = READ;
            end else begin
               oe_n_d  = 1'b0;
               rd_n_d  = 1'b1;
               state_d = PAUSE;
            end
         end
         READ: begin
            if (ftdi_rxf_n) begin
               oe_n_d  = 1'b1;
               rd_n_d  = 1'b1;
               state_d = IDLE;
            end else if (!space_s) begin
               oe_n_d  = 1'b0;
               rd_n_d  = 1'b1;
               state_d = PAUSE;
            end else begin
               oe_n_d  = 1'b0;
               rd_n_d  = 1'b0;
               state_d = READ;
            end
         end
         PAUSE: begin
            if (ftdi_rxf_n) begin
               oe_n_d  = 1'b1;
               rd_n_d  = 1'b1;
               state_d = IDLE;
            end else if (space_s) begin
               oe_n_d  = 1'b0;
               rd_n_d  = 1'b0;
               state_d = READ;
            end else begin
               oe_n_d  = 1'b0;
               rd_n_d  = 1'b1;
               state_d = PAUSE;
            end
         end
         default: begin
            oe_n_d  = 1'b1;
            rd_n_d  = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   // Sequencer state and registered bus strobes
   always_ff @(posedge ftdi_clk) begin
      if (ftdi_reset) begin
         state_q <= IDLE;
         oe_n_q  <= 1'b1;
         rd_n_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         oe_n_q  <= oe_n_d;
         rd_n_q  <= rd_n_d;
      end
   end

   assign ftdi_oe_n        = oe_n_q;
   assign ftdi_rd_n        = rd_n_q;
   assign host_axis_tvalid = tvalid_s;

`ifdef FT232H_RX_BYTE_COUNT_EN
   logic [31:0] byte_cnt_q, byte_cnt_d;

   // Capture counter next value; wraps freely at 32 bits
   always_comb begin
      if (capture_s) begin
         byte_cnt_d = byte_cnt_q + 32'd1;
      end else begin
         byte_cnt_d = byte_cnt_q;
      end
   end

   // Capture counter register
   always_ff @(posedge ftdi_clk) begin
      if (ftdi_reset) begin
         byte_cnt_q <= 32'd0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
      end
   end

   assign rx_byte_count = byte_cnt_q;
`endif

endmodule

// File: tb/tb_ft232h_rx.sv
// Self-checking bench for ft232h_rx: an FTDI-side model offers bytes and records every
// byte the DUT strobes out of it; a scoreboard queue holds the bytes that must appear on
// the AXI-Stream side in order, and a separate monitor pops and compares them.
module tb_ft232h_rx;

   localparam int BUF_DEPTH = 4;

   logic       clk = 1'b0;
   logic       ftdi_reset;
   logic       rxf_n;
   logic       oe_n;
   logic       rd_n;
   logic [7:0] adbus;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;
`ifdef FT232H_RX_BYTE_COUNT_EN
   logic [31:0] rx_byte_count;
`endif

   always #5 clk = ~clk;

   ft232h_rx #(.BUF_DEPTH(BUF_DEPTH)) dut (
      .ftdi_clk         (clk),
      .ftdi_reset       (ftdi_reset),
      .ftdi_rxf_n       (rxf_n),
      .ftdi_oe_n        (oe_n),
      .ftdi_rd_n        (rd_n),
      .ftdi_adbus       (adbus),
      .host_axis_tdata  (tdata),
      .host_axis_tvalid (tvalid),
      .host_axis_tready (tready)
`ifdef FT232H_RX_BYTE_COUNT_EN
      ,
      .rx_byte_count    (rx_byte_count)
`endif
   );

   int passed = 0;
   int total  = 0;

   logic [7:0] src_q[$];   // bytes the FTDI still holds for the FPGA
   logic [7:0] exp_q[$];   // bytes captured by the DUT, not yet seen on AXIS
   int  captures  = 0;
   int  delivered = 0;
   bit  rand_tready = 1'b0;
   bit  rand_rxf    = 1'b0;
   bit  gap         = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void refresh();
      rxf_n = (src_q.size() == 0) || gap;
      adbus = (src_q.size() != 0) ? src_q[0] : 8'h00;
   endfunction

   // FTDI model: a byte leaves the FTDI on any edge where RD# and RXF# are both low
   initial begin
      bit wc;
      bit re;
      logic [7:0] b;
      forever begin
         @(negedge clk); #4;
         wc = (rd_n == 1'b0) && (rxf_n == 1'b0);
         re = ftdi_reset;
         @(posedge clk); #1;
         if (re) exp_q.delete();
         if (wc && src_q.size() > 0) begin
            b = src_q.pop_front();
            if (!re) begin
               exp_q.push_back(b);
               captures++;
            end
         end
         if (rand_tready) tready = 1'($urandom_range(0, 1));
         gap = rand_rxf && ($urandom_range(0, 3) == 0);
         refresh();
      end
   end

   // AXIS monitor and protocol watcher
   initial begin
      logic prev_oe_n = 1'b1;
      logic prev_rd_n = 1'b1;
      logic [7:0] e;
      forever begin
         @(negedge clk); #4;
         if (!rd_n && oe_n) check("rd_low_with_oe_high", 32'(rd_n), 32'd1);
         if (prev_rd_n && !rd_n) check("rd_fall_after_oe", 32'(prev_oe_n), 32'd0);
         if (exp_q.size() > BUF_DEPTH) check("buffer_overflow", 32'(exp_q.size()), 32'(BUF_DEPTH));
         check("tvalid_vs_model", 32'(tvalid), 32'(exp_q.size() != 0));
         if (tvalid && tready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("axis_tdata", 32'(tdata), 32'(e));
            delivered++;
         end
         prev_oe_n = oe_n;
         prev_rd_n = rd_n;
      end
   end

   task automatic step();
      @(negedge clk); #2;
   endtask

   task automatic push_bytes(input logic [7:0] v);
      src_q.push_back(v);
      refresh();
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while ((src_q.size() != 0 || exp_q.size() != 0 || tvalid) && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) check({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      int c0;
      int d0;
      int n;
      ftdi_reset = 1'b1;
      tready     = 1'b0;
      rxf_n      = 1'b1;
      adbus      = 8'h00;
      repeat (3) step();
      ftdi_reset = 1'b0;

      // 1: idle with RXF# high
      for (int i = 0; i < 20; i++) begin
         step();
         check("idle_oe_n", 32'(oe_n), 32'd1);
         check("idle_rd_n", 32'(rd_n), 32'd1);
         check("idle_tvalid", 32'(tvalid), 32'd0);
      end

      // 2: three bytes with tready high
      tready = 1'b1;
      c0 = captures; d0 = delivered;
      push_bytes(8'hA1); push_bytes(8'hB2); push_bytes(8'hC3);
      check("t2_oe_before", 32'(oe_n), 32'd1);
      step();
      check("t2_oe_edge1", 32'(oe_n), 32'd0);
      check("t2_rd_edge1", 32'(rd_n), 32'd1);
      step();
      check("t2_rd_edge2", 32'(rd_n), 32'd0);
      n = 0;
      while (!rxf_n && n < 20) begin step(); n++; end
      check("t2_rd_low_before_rxf_rise", 32'(rd_n), 32'd0);
      step();
      check("t2_oe_after_rxf", 32'(oe_n), 32'd1);
      check("t2_rd_after_rxf", 32'(rd_n), 32'd1);
      wait_drain("t2", 50);
      check("t2_captures", 32'(captures - c0), 32'd3);
      check("t2_delivered", 32'(delivered - d0), 32'd3);

      // 3: backpressure fills the buffer, then release
      tready = 1'b0;
      c0 = captures; d0 = delivered;
      for (int i = 0; i < 10; i++) push_bytes(8'(8'h10 + i));
      repeat (30) step();
      check("t3_captures_full", 32'(captures - c0), 32'd4);
      check("t3_pause_oe_n", 32'(oe_n), 32'd0);
      check("t3_pause_rd_n", 32'(rd_n), 32'd1);
      tready = 1'b1;
      wait_drain("t3", 200);
      check("t3_captures_all", 32'(captures - c0), 32'd10);
      check("t3_delivered", 32'(delivered - d0), 32'd10);

      // 4: random stream with random backpressure and RXF# gaps
      c0 = captures; d0 = delivered;
      rand_tready = 1'b1;
      rand_rxf    = 1'b1;
      for (int i = 0; i < 1000; i++) src_q.push_back(8'($urandom_range(0, 255)));
      refresh();
      wait_drain("t4", 30000);
      rand_tready = 1'b0;
      rand_rxf    = 1'b0;
      step();
      tready = 1'b1;
      wait_drain("t4_tail", 50);
      check("t4_captures", 32'(captures - c0), 32'd1000);
      check("t4_delivered", 32'(delivered - d0), 32'd1000);

      // 5: reset in READ with two bytes buffered
      tready = 1'b0;
      for (int i = 0; i < 6; i++) push_bytes(8'(8'h60 + i));
      n = 0;
      while (!(exp_q.size() == 2 && rd_n == 1'b0) && n < 30) begin step(); n++; end
      if (n >= 30) check("t5_reach_read_timeout", 32'd0, 32'd1);
      check("t5_in_read_rd_n", 32'(rd_n), 32'd0);
      ftdi_reset = 1'b1;
      src_q.delete();
      refresh();
      step();
      check("t5_reset_oe_n", 32'(oe_n), 32'd1);
      check("t5_reset_rd_n", 32'(rd_n), 32'd1);
      check("t5_reset_tvalid", 32'(tvalid), 32'd0);
      ftdi_reset = 1'b0;
      step();
      c0 = captures; d0 = delivered;
      tready = 1'b1;
      push_bytes(8'h5A); push_bytes(8'hA5); push_bytes(8'h3C);
      wait_drain("t5", 100);
      check("t5_delivered_new", 32'(delivered - d0), 32'd3);

`ifdef FT232H_RX_BYTE_COUNT_EN
      // 6: counter wraps through zero
      force dut.byte_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.byte_cnt_q;
      step();
      push_bytes(8'h01); push_bytes(8'h02); push_bytes(8'h03);
      wait_drain("t6", 100);
      check("t6_byte_count_wrap", rx_byte_count, 32'd1);
`endif

      check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
